ps2_keyboard_ascii: RTL and testbench
=====================================

# ps2_keyboard_ascii

Receives PS/2 keyboard frames (scan code set 2, US layout) and turns make codes into 8-bit ASCII characters with a one-cycle write strobe. Its outputs `data` and `write_en` drive the LCD character-buffer controller's `data`/`write_en` inputs directly. It is the producer side of that character interface: printable ASCII 0x20–0x7E, 0x0D on Enter, 0x08 on Backspace.

## Interface

Parameters:
- FILTER_LEN, 8 — consecutive equal `ps2_clk` samples required before the filtered level changes.
- TIMEOUT_CYCLES, 50000 — maximum idle clocks between falling edges inside a frame before the frame is aborted.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to `clock`.
- ps2_dat  in  1  raw PS/2 data, asynchronous to `clock`.
- data  out  8  last emitted ASCII character; held until the next emission.
- write_en  out  1  high for exactly one cycle, on the cycle `data` takes its new value.
- frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation

- **Input conditioning:** 2-flop synchronizers on both inputs. `ps2_clk` then passes through the FILTER_LEN glitch filter. A falling edge of the filtered clock samples synchronized `ps2_dat`.
- **Frame FSM: IDLE → BITS → CHECK → IDLE.**
  - IDLE: on a falling edge with dat=0 (start bit), go to BITS with bit count 0. A falling edge with dat=1 is ignored.
  - BITS: capture 8 data bits LSB first, then parity, then stop; 10 edges total.
  - CHECK: one cycle. A byte is valid when data plus parity has an odd number of ones and stop=1. Valid asserts internal `byte_valid` for one cycle; invalid pulses `frame_err`.
  - Timeout: in BITS, TIMEOUT_CYCLES clocks without a falling edge returns to IDLE and pulses `frame_err`. The partial byte is discarded.
- **Decode FSM: NORMAL, BRK, EXT, EXT_BRK.** It consumes only `byte_valid` bytes.
  - NORMAL: 0xF0 → BRK; 0xE0 → EXT; any other byte is a make code, handled by the make rules below.
  - BRK: the byte is a break code. 0x12 clears lshift, 0x59 clears rshift. Go to NORMAL. Nothing is emitted.
  - EXT: 0xF0 → EXT_BRK. 0x5A emits 0x0D. Any other byte is ignored. Go to NORMAL.
  - EXT_BRK: the byte is ignored; go to NORMAL.
- **Make rules:**
  - 0x12 sets lshift; 0x59 sets rshift; 0x58 toggles caps. None of these emit.
  - shift = lshift | rshift.
  - Letters: uppercase when shift XOR caps, else lowercase.
  - Digit row: shift selects the US symbols `)!@#$%^&*(`; caps has no effect.
  - 0x29 → 0x20; 0x5A → 0x0D; 0x66 → 0x08.
  - Unmapped codes emit nothing.
  - Auto-repeat make codes emit again each time.
- **Reset values:** data=0x00, write_en=0, frame_err=0, shifts and caps cleared, both FSMs in IDLE/NORMAL, filter and counters zeroed.

## Timing

- A CHECK cycle is the cycle after the stop bit's sampling edge.
- `byte_valid` (or `frame_err`) asserts in the cycle after CHECK is entered.
- `data`/`write_en` update on the next cycle. Latency is 2 clocks from CHECK entry to `write_en`.
- `write_en` never asserts on consecutive cycles. Each byte needs at least 10 filtered edges, so back-to-back emissions are thousands of cycles apart.
- Reset mid-frame discards the frame. The first falling edge after reset with dat=0 starts a new frame. Edges within FILTER_LEN+2 cycles of reset release may be lost.
- A glitch on `ps2_clk` shorter than FILTER_LEN cycles produces no edge.

## Structure

- **Package `ps2_pkg`:**
  - Frame and decode state enums.
  - Scan code constants SC_BREAK=0xF0, SC_EXT=0xE0, SC_LSHIFT=0x12, SC_RSHIFT=0x59, SC_CAPS=0x58, SC_ENTER=0x5A, SC_SPACE=0x29, SC_BKSP=0x66.
  - ASCII constants.
  - Function `sc_to_ascii(code, upper, shift)` returning {valid, char}.
- **Sub-module `ps2_frame_rx`:** synchronizers, glitch filter, frame FSM and timeout. Outputs `byte`, `byte_valid`, `frame_err`.
- **Top level:** the decode FSM, modifier flags and output registers.

## Test plan

1. Frame 0x1C, parity 0 → exactly one `write_en` pulse with data=0x61, 2 clocks after CHECK; frame_err stays 0.
2. Frames 12, 1C, F0 1C, F0 12 → a single emission, 0x41. A following 1C → 0x61.
3. Frames 58, F0 58, 1C → 0x41. Then 12, 1C → 0x61. Then 16 with shift still held → 0x21.
4. Frame 5A → 0x0D. Frames E0 5A → 0x0D. Frames E0 F0 5A → no emission.
5. Frame 0x1C with parity 1 → frame_err pulse, no `write_en`. The next good 0x29 → 0x20.
6. Start plus 4 bits, then stall TIMEOUT_CYCLES+1 → frame_err pulse and return to IDLE. Then assert reset mid-frame → all outputs 0. After release, frame 0x45 → 0x30.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, scan-code/ASCII constants and the scan code set 2
// (US layout) to ASCII lookup used by the PS/2 keyboard receiver.
// Contents: frame_state_t, dec_state_t, SC_* / ASCII_* constants, sc_to_ascii().
package ps2_pkg;

  typedef enum logic [1:0] {FR_IDLE, FR_BITS, FR_CHECK} frame_state_t;
  typedef enum logic [1:0] {DEC_NORMAL, DEC_BRK, DEC_EXT, DEC_EXT_BRK} dec_state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Returns {valid, char}. 'upper' applies to letters only, 'shift' to the
  // digit row only, so the caller decides how caps lock combines with shift.
  function automatic logic [8:0] sc_to_ascii(input logic [7:0] code,
                                             input logic upper,
                                             input logic shift);
    logic [7:0] ch;
    logic       v;
    ch = 8'h00;
    v  = 1'b1;
    case (code)
      8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
      8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
      8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
      8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
      8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
      8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
      8'h35: ch = "y";  8'h1A: ch = "z";
      8'h16: ch = shift ? "!" : "1";
      8'h1E: ch = shift ? "@" : "2";
      8'h26: ch = shift ? "#" : "3";
      8'h25: ch = shift ? "$" : "4";
      8'h2E: ch = shift ? "%" : "5";
      8'h36: ch = shift ? "^" : "6";
      8'h3D: ch = shift ? "&" : "7";
      8'h3E: ch = shift ? "*" : "8";
      8'h46: ch = shift ? "(" : "9";
      8'h45: ch = shift ? ")" : "0";
      SC_SPACE: ch = ASCII_SPACE;
      SC_ENTER: ch = ASCII_CR;
      SC_BKSP:  ch = ASCII_BS;
      default:  v  = 1'b0;
    endcase
    // Letters were looked up lowercase; fold to uppercase here.
    if (upper && ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
    return {v, ch};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes and glitch-filters the PS/2 lines and assembles
// 11-bit frames into bytes with odd-parity, stop-bit and inactivity checks.
// Ports: clock, reset, ps2_clk_i, ps2_dat_i -> byte_o, byte_valid_o, frame_err_o.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_filt_q;
  logic [FW-1:0] filt_cnt_q;
  frame_state_t  state_q;
  logic [3:0]    bit_cnt_q;
  logic [9:0]    shift_q;     // {stop, parity, data[7:0]} once full
  logic [TW-1:0] to_cnt_q;
  logic [7:0]    byte_q;
  logic          byte_valid_q, frame_err_q;

  logic dat_s, fall_edge;

  assign dat_s = dat_sync_q[1];
  // The filtered clock drops on exactly the cycle the filter accepts a low level.
  assign fall_edge = clk_filt_q & ~clk_sync_q[1] & (filt_cnt_q == FILT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q   <= '0;
      dat_sync_q   <= '0;
      clk_filt_q   <= 1'b0;
      filt_cnt_q   <= '0;
      state_q      <= FR_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      to_cnt_q     <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q   <= {dat_sync_q[0], ps2_dat_i};
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;

      // Any sample matching the current level restarts the run count.
      if (clk_sync_q[1] != clk_filt_q) begin
        if (filt_cnt_q == FILT_LAST) begin
          clk_filt_q <= clk_sync_q[1];
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + 1'b1;
        end
      end else begin
        filt_cnt_q <= '0;
      end

      case (state_q)
        FR_IDLE: begin
          if (fall_edge && !dat_s) begin
            state_q   <= FR_BITS;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
          end
        end
        FR_BITS: begin
          if (fall_edge) begin
            shift_q  <= {dat_s, shift_q[9:1]};
            to_cnt_q <= '0;
            if (bit_cnt_q == 4'd9) state_q <= FR_CHECK;
            else                   bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (to_cnt_q == TO_LAST) begin
            state_q     <= FR_IDLE;
            frame_err_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        FR_CHECK: begin
          if ((^shift_q[8:0]) && shift_q[9]) byte_valid_q <= 1'b1;
          else                               frame_err_q  <= 1'b1;
          byte_q  <= shift_q[7:0];
          state_q <= FR_IDLE;
        end
        default: state_q <= FR_IDLE;
      endcase
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_keyboard_ascii.sv
// ps2_keyboard_ascii: PS/2 keyboard to ASCII character stream for the LCD buffer.
// Ports: clock, reset, ps2_clk, ps2_dat -> data (held char), write_en (1-cycle
// strobe with new data), frame_err (1-cycle pulse on a bad or timed-out frame).
module ps2_keyboard_ascii
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       write_en,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_vld;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk_i   (ps2_clk),
    .ps2_dat_i   (ps2_dat),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_vld),
    .frame_err_o (frame_err)
  );

  dec_state_t dec_q;
  logic       lshift_q, rshift_q, caps_q;
  logic [7:0] data_q;
  logic       write_en_q;
  logic       shift;
  logic [8:0] lut;

  assign shift = lshift_q | rshift_q;
  assign lut   = sc_to_ascii(rx_byte, shift ^ caps_q, shift);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_q      <= DEC_NORMAL;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      caps_q     <= 1'b0;
      data_q     <= 8'h00;
      write_en_q <= 1'b0;
    end else begin
      write_en_q <= 1'b0;
      if (rx_vld) begin
        case (dec_q)
          DEC_NORMAL: begin
            if (rx_byte == SC_BREAK)       dec_q    <= DEC_BRK;
            else if (rx_byte == SC_EXT)    dec_q    <= DEC_EXT;
            else if (rx_byte == SC_LSHIFT) lshift_q <= 1'b1;
            else if (rx_byte == SC_RSHIFT) rshift_q <= 1'b1;
            else if (rx_byte == SC_CAPS)   caps_q   <= ~caps_q;
            else if (lut[8]) begin
              data_q     <= lut[7:0];
              write_en_q <= 1'b1;
            end
          end
          DEC_BRK: begin
            if (rx_byte == SC_LSHIFT) lshift_q <= 1'b0;
            if (rx_byte == SC_RSHIFT) rshift_q <= 1'b0;
            dec_q <= DEC_NORMAL;
          end
          DEC_EXT: begin
            // Keypad Enter is the only extended key that produces a character.
            if (rx_byte == SC_BREAK) begin
              dec_q <= DEC_EXT_BRK;
            end else begin
              if (rx_byte == SC_ENTER) begin
                data_q     <= ASCII_CR;
                write_en_q <= 1'b1;
              end
              dec_q <= DEC_NORMAL;
            end
          end
          default: dec_q <= DEC_NORMAL;
        endcase
      end
    end
  end

  assign data     = data_q;
  assign write_en = write_en_q;

endmodule

// File: tb/tb_ps2_keyboard_ascii.sv
module tb_ps2_keyboard_ascii;

  localparam int FILT = 8;
  localparam int TO   = 1000;
  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] data;
  logic       write_en;
  logic       frame_err;

  ps2_keyboard_ascii #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .data     (data),
    .write_en (write_en),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int         we_cnt = 0, err_cnt = 0, b2b = 0, last_we_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic       prev_we = 1'b0;
  always @(negedge clock) begin
    if (write_en) begin
      we_cnt++;
      last_data = data;
      last_we_cyc = cyc;
      if (prev_we) b2b++;
    end
    prev_we = write_en;
    if (frame_err) err_cnt++;
  end

  int n_cmp = 0, n_bad = 0;
  int base_we = 0, base_err = 0, last_fall_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    step(HALF);
    last_fall_cyc = cyc;
    ps2_clk = 1'b0;
    step(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad_par);
    send_bit(1'b1);
    ps2_dat = 1'b1;
    step(40);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(b[i]);
    ps2_dat = 1'b1;
  endtask

  task automatic mark();
    base_we  = we_cnt;
    base_err = err_cnt;
  endtask

  // One emission of 'ch' expected since the last mark, no frame errors.
  task automatic expect_one(input string tag, input logic [7:0] ch);
    chk({tag, "_cnt"}, we_cnt - base_we, 1);
    chk({tag, "_dat"}, last_data, ch);
    chk({tag, "_err"}, err_cnt - base_err, 0);
  endtask

  initial begin
    step(3);
    chk("rst_data", data, 8'h00);
    chk("rst_we", write_en, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    reset = 1'b0;
    step(30);

    // 1: plain 'a' with latency from the stop bit's raw falling edge:
    // 2 sync + FILT filter cycles to the edge/CHECK entry, then 2 to write_en.
    mark();
    send_frame(8'h1C, 1'b0);
    expect_one("t1_a", 8'h61);
    chk("t1_lat", last_we_cyc - last_fall_cyc, FILT + 4);

    // 2: shifted 'A', break codes emit nothing, then shift released.
    mark();
    send_frame(8'h12, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0); send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0); send_frame(8'h12, 1'b0);
    expect_one("t2_A", 8'h41);
    mark();
    send_frame(8'h1C, 1'b0);
    expect_one("t2_a", 8'h61);

    // 3: caps on -> 'A'; shift+caps -> 'a'; shift digit -> '!'.
    mark();
    send_frame(8'h58, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h58, 1'b0);
    send_frame(8'h1C, 1'b0);
    expect_one("t3_caps", 8'h41);
    mark();
    send_frame(8'h12, 1'b0); send_frame(8'h1C, 1'b0);
    expect_one("t3_shcaps", 8'h61);
    mark();
    send_frame(8'h16, 1'b0);
    expect_one("t3_bang", 8'h21);
    // Release shift; caps alone leaves digits unshifted.
    mark();
    send_frame(8'hF0, 1'b0); send_frame(8'h12, 1'b0);
    send_frame(8'h16, 1'b0);
    expect_one("t3_digit", 8'h31);
    send_frame(8'h58, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h58, 1'b0);

    // 4: Enter, keypad Enter, keypad Enter break, Backspace.
    mark();
    send_frame(8'h5A, 1'b0);
    expect_one("t4_cr", 8'h0D);
    mark();
    send_frame(8'hE0, 1'b0); send_frame(8'h5A, 1'b0);
    expect_one("t4_kpcr", 8'h0D);
    mark();
    send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h5A, 1'b0);
    chk("t4_kpbrk_cnt", we_cnt - base_we, 0);
    mark();
    send_frame(8'h66, 1'b0);
    expect_one("t4_bs", 8'h08);

    // 5: parity error, then a good space.
    mark();
    send_frame(8'h1C, 1'b1);
    chk("t5_perr_err", err_cnt - base_err, 1);
    chk("t5_perr_cnt", we_cnt - base_we, 0);
    mark();
    send_frame(8'h29, 1'b0);
    expect_one("t5_sp", 8'h20);

    // 6: timeout mid-frame, recovery, then reset mid-frame.
    mark();
    send_partial(8'h1C, 4);
    step(TO + 40);
    chk("t6_to_err", err_cnt - base_err, 1);
    chk("t6_to_cnt", we_cnt - base_we, 0);
    mark();
    send_frame(8'h1C, 1'b0);
    expect_one("t6_after_to", 8'h61);
    send_partial(8'h45, 3);
    reset = 1'b1;
    step(2);
    chk("t6_rst_data", data, 8'h00);
    chk("t6_rst_we", write_en, 1'b0);
    chk("t6_rst_err", frame_err, 1'b0);
    reset = 1'b0;
    step(30);
    mark();
    send_frame(8'h45, 1'b0);
    expect_one("t6_zero", 8'h30);

    chk("no_b2b", b2b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
